maxnet_controller: RTL
======================

Name: maxnet_controller

Overview:
- Control FSM that drives the MaxNet datapath: loads the four input activations, iterates the four PUs until at most one activation is non-zero, then reports completion.
- Generates init_x, init_w, load_a and load_sel toward the datapath; consumes its is_finished flag.
- Exposes a start/done handshake to the top level, plus an iteration count and a timeout flag for non-converging inputs.

Parameters:
- MAX_ITER, 64, maximum ITER cycles before the run is aborted with timeout.
- PU_LAT, 1, clock cycles between an activation-register update and a valid PU output (PU is registered); legal range 0..7.
- CNT_W, 7, width of iter_count; must satisfy 2^CNT_W > MAX_ITER.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new run; sampled only in IDLE.
- is_finished  in  1  datapath flag: at most one activation non-zero.
- init_x  out  1  one-cycle pulse that initialises the X memory.
- init_w  out  1  one-cycle pulse that initialises the W memory.
- load_a  out  1  activation register load enable.
- load_sel  out  1  activation mux select: 1 = X memory, 0 = PU outputs.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- result_valid  out  1  datapath res is valid; held until the next accepted start.
- timeout  out  1  last run hit MAX_ITER without converging; held with result_valid.
- iter_count  out  CNT_W  ITER cycles executed in the current or last run.

Behaviour:
- Reset (async assert, sync release): state = IDLE; every output = 0; iter_count = 0; wait counter = 0.
- Reset mid-run: abort immediately to the reset values; no done pulse.
- All outputs are registered or decoded from registered state only; no combinational path from start or is_finished to any output.
- States and transitions:
  - IDLE: if start = 1, go to INIT; clear result_valid, timeout and iter_count on the same edge.
  - INIT, 1 cycle: init_x = init_w = 1; go to LOADX.
  - LOADX, 1 cycle: load_a = 1, load_sel = 1; go to EVAL.
  - EVAL, 1 cycle: is_finished is sampled in this cycle. Priority order:
    - is_finished = 1: go to DONE.
    - else iter_count == MAX_ITER: set timeout, go to DONE.
    - else if PU_LAT = 0: go to ITER.
    - else load wait counter with PU_LAT-1 and go to WAIT.
  - WAIT: decrement the wait counter; go to ITER when it reaches 0. WAIT lasts PU_LAT cycles.
  - ITER, 1 cycle: load_a = 1, load_sel = 0; iter_count += 1; go to EVAL.
  - DONE, 1 cycle: done = 1; result_valid <= 1; go to IDLE unconditionally. A start seen in DONE is ignored.
- Outputs by state:
  - load_sel is 0 in every state except LOADX.
  - load_a is 1 only in LOADX and ITER.
  - busy = (state != IDLE).
- iter_count saturates at MAX_ITER and never wraps.
- Inputs that are already converged (one non-zero at load) finish with iter_count = 0.
- start held high continuously: a new run begins in the IDLE cycle after each DONE.
- An is_finished change outside EVAL is ignored.
- Latency from start accepted to done, with N = ITER count: 3 + N*(PU_LAT+2) + 1 cycles.

Test Plan:
- Reset and idle: reset asserted with start = 1, then released with start = 0 → all outputs 0, state held in IDLE, busy = 0.
- Already converged, PU_LAT = 1: pulse start with is_finished forced to 1 after LOADX → init pulse in cycle 1, load_a with load_sel = 1 in cycle 2, done in cycle 4, iter_count = 0, timeout = 0.
- Three iterations, PU_LAT = 1: is_finished goes to 1 after the 3rd ITER → exactly 3 load_a pulses with load_sel = 0, iter_count = 3, done at cycle 4 + 3*3 = 13, result_valid held until the next start.
- Non-converging input, MAX_ITER = 4: is_finished tied to 0 → 4 ITER pulses, timeout = 1, done pulses, iter_count = 4 with no wrap.
- Reset mid-run: assert rst_n = 0 during the second WAIT → outputs cleared asynchronously, no done pulse; a subsequent start runs normally from INIT.
- Start handling: pulse start while busy and again in the DONE cycle → both ignored; start held high continuously → back-to-back runs, each with its own INIT pulse and done pulse.

Source files
------------

// File: rtl/maxnet_controller.sv
// MaxNet control FSM: loads the activations, iterates the PUs until the datapath
// reports convergence or MAX_ITER is reached, then pulses done.
module maxnet_controller #(
  parameter int unsigned MAX_ITER = 64,
  parameter int unsigned PU_LAT   = 1,
  parameter int unsigned CNT_W    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_finished,
  output logic             init_x,
  output logic             init_w,
  output logic             load_a,
  output logic             load_sel,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic             timeout,
  output logic [CNT_W-1:0] iter_count
);

  localparam int unsigned WAIT_W = 3;
  localparam int unsigned WAIT_LOAD_I = (PU_LAT > 0) ? PU_LAT - 1 : 0;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_LOAD_I);
  localparam logic [CNT_W-1:0]  ITER_MAX  = CNT_W'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOADX, S_EVAL, S_WAIT, S_ITER, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  iter_d;
  logic              result_valid_d, timeout_d;
  logic              init_d, load_a_d, load_sel_d, busy_d, done_d;

  // Next-state, counters and next-cycle output decode.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    iter_d         = iter_count;
    result_valid_d = result_valid;
    timeout_d      = timeout;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_INIT;
          result_valid_d = 1'b0;
          timeout_d      = 1'b0;
          iter_d         = '0;
        end
      end
      S_INIT:  state_d = S_LOADX;
      S_LOADX: state_d = S_EVAL;
      S_EVAL: begin
        if (is_finished) begin
          state_d = S_DONE;
        end else if (iter_count == ITER_MAX) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else if (PU_LAT == 0) begin
          state_d = S_ITER;
        end else begin
          wait_d  = WAIT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_ITER;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_ITER: begin
        if (iter_count != ITER_MAX) begin
          iter_d = iter_count + CNT_W'(1);
        end
        state_d = S_EVAL;
      end
      S_DONE: begin
        result_valid_d = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    init_d     = (state_d == S_INIT);
    load_a_d   = (state_d == S_LOADX) || (state_d == S_ITER);
    load_sel_d = (state_d == S_LOADX);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      iter_count   <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      init_x       <= 1'b0;
      init_w       <= 1'b0;
      load_a       <= 1'b0;
      load_sel     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      iter_count   <= iter_d;
      result_valid <= result_valid_d;
      timeout      <= timeout_d;
      init_x       <= init_d;
      init_w       <= init_d;
      load_a       <= load_a_d;
      load_sel     <= load_sel_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule
